vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Dispense sequencer downstream of the vending FSM. It captures each vend/change event from the FSM's `out` and `change` outputs into a small FIFO, then drives the bottle motor and the 5-rs coin hopper one action at a time. Each action uses a request/acknowledge handshake, a timeout and an inter-action guard gap. This decouples the single-cycle FSM outputs from the slow electromechanical actuators.

## Interface
Parameters:
- DEPTH, 4: event FIFO entries (power of two, ≥2).
- TIMEOUT, 1000: maximum cycles an action waits for its acknowledge before a fault is raised.
- GAP, 4: idle cycles inserted after every completed action.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vend_i  in  1  one-cycle vend pulse from the vending FSM (`out`).
- change_i  in  2  change code from the FSM: 00 none, 01 = 5 rs (one coin), 10 = 10 rs (two coins), 11 reserved.
- motor_on  out  1  bottle motor request, held until acknowledged.
- motor_done  in  1  motor cycle-complete sensor.
- coin_eject  out  1  hopper request for a single 5-rs coin, held until acknowledged.
- coin_ack  in  1  hopper coin-out sensor.
- clr  in  1  synchronous clear of `fault` and `overflow`.
- busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- fault  out  1  sticky; set on an action timeout.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- vend_count, coin_count  out  16 each  statistics counters (see Configuration).

## Operation
- **Event capture:** an event is any cycle with `vend_i`=1 or `change_i` ∈ {01,10}.
  - It is pushed as {vend, ncoins}, where ncoins is 0, 1 or 2.
  - `change_i`=11 with `vend_i`=0 is ignored. With `vend_i`=1 it is pushed as {1,0}.
- **Full FIFO:**
  - A push with no same-cycle pop is dropped and sets `overflow`.
  - A push together with a pop on a full FIFO is accepted.
- **FSM states:** IDLE, MOTOR, COIN, GAP, FAULT.
- **IDLE:** when the FIFO is non-empty, pop the head and load the pending vend flag and coin count.
  - Next state is MOTOR if vend=1, otherwise COIN.
- **MOTOR:** `motor_on`=1.
  - On `motor_done` sampled high, clear the vend flag and go to GAP.
- **COIN:** `coin_eject`=1.
  - On `coin_ack` sampled high, decrement the coin count and go to GAP.
- **GAP:** all actuator outputs 0 for GAP cycles. Then:
  - vend flag still set → MOTOR;
  - coins remaining → COIN;
  - otherwise → IDLE.
- **Timeout:** the cycle counter clears on entry to MOTOR or COIN. If it reaches TIMEOUT without an acknowledge:
  - go to FAULT, set `fault`, and deassert all actuator outputs;
  - discard the remainder of the current event.
- **FAULT:** the FIFO keeps accepting events, but no pops occur. `clr` returns the FSM to IDLE and clears `fault`; queued events are preserved.
- **clr outside FAULT:** clears `overflow` only.
- **Reset:** clears the FIFO, counters, pending state and all flags. The FSM goes to IDLE.
- **Reset values:** every output is 0, including `level`, `vend_count` and `coin_count`.

## Timing
- Event sampled at edge N:
  - `level` increments after edge N.
  - The pop happens at edge N+1.
  - `motor_on` or `coin_eject` is high after edge N+1 (two cycles after the event, Moore/registered).
- An acknowledge sampled at edge M drops the request after edge M; GAP then occupies cycles M+1..M+GAP.
- Acknowledges seen outside their own state are ignored. `motor_done` during COIN has no effect.
- Timeout fires at the edge where the counter equals TIMEOUT-1 with no acknowledge. `fault` is high after that edge.
- Back-to-back events on consecutive cycles are both queued; `level`=2 if no pop has occurred.
- `clr` and a timeout in the same cycle: the timeout wins and `fault` stays set.
- `rst_n` deasserted mid-action: all outputs drop immediately (asynchronously).

## Configuration
- `VEND_DISP_STATS_EN` defined:
  - `vend_count` increments on each acknowledged motor action.
  - `coin_count` increments on each acknowledged coin.
  - Both saturate at 16'hFFFF and are cleared only by reset.
- Not defined: both outputs are tied to 0 and no counter logic is synthesized.

## Test plan
- **Vend only:** `vend_i`=1 at cycle 10, `motor_done` after 5 cycles.
  - Expect `motor_on` high cycles 12–16, GAP of 4, then `busy`=0 and `vend_count`=1 (STATS on).
- **Vend with 10-rs change:** `vend_i`=1 and `change_i`=10 together.
  - Expect motor → GAP → coin → GAP → coin → GAP → IDLE, with exactly 2 `coin_eject` pulses.
- **Overflow:** 5 events pushed on consecutive cycles with `motor_done` held 0 and DEPTH=4.
  - One pop occurs, so `level` peaks at 4, no drop occurs and `overflow`=0.
  - A 6th event while full sets `overflow`=1; `clr` clears it.
- **Timeout:** `motor_done` never asserts with TIMEOUT=20.
  - Expect `fault`=1 20 cycles after `motor_on` rises, with `motor_on`=0.
  - After `clr`, the next queued event starts within 2 cycles.
- **Async reset mid-COIN:** assert `rst_n`=0 while `coin_eject`=1.
  - Expect all outputs 0 immediately and `level`=0; no action after release until a new event.
- **Reserved code:** `change_i`=11 with `vend_i`=0.
  - Expect `level` unchanged and no actuator activity.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues vend/change events from the vending FSM and
// drives the motor and coin hopper one handshaked action at a time. Optional stats: VEND_DISP_STATS_EN.
module vend_dispense_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    parameter int GAP     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vend_i,
    input  logic [1:0]               change_i,
    output logic                     motor_on,
    input  logic                     motor_done,
    output logic                     coin_eject,
    input  logic                     coin_ack,
    input  logic                     clr,
    output logic                     busy,
    output logic                     fault,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              vend_count,
    output logic [15:0]              coin_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_MOTOR, S_COIN, S_GAP, S_FAULT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            r_vend;
    logic [1:0]      r_coins;
    logic [CW-1:0]   r_cnt;
    logic            r_fault;
    logic            r_overflow;

    logic            w_evt;
    logic [1:0]      w_ncoins;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [2:0]      w_head;
    logic            w_motor_ack;
    logic            w_coin_ack;
    logic            w_acting;
    logic            w_timeout;
    logic            w_gap_done;

    // Reserved code 11 carries no coins; it only matters if vend_i rides along.
    always_comb begin
        w_ncoins = 2'd0;
        case (change_i)
            2'b01:   w_ncoins = 2'd1;
            2'b10:   w_ncoins = 2'd2;
            default: w_ncoins = 2'd0;
        endcase
    end

    assign w_evt       = vend_i | (change_i == 2'b01) | (change_i == 2'b10);
    assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
    assign w_full      = (r_level == FULL_LVL);
    assign w_push      = w_evt && (!w_full || w_pop);
    assign w_drop      = w_evt && w_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_motor_ack = (r_state == S_MOTOR) && motor_done;
    assign w_coin_ack  = (r_state == S_COIN) && coin_ack;
    assign w_acting    = (r_state == S_MOTOR) || (r_state == S_COIN);
    assign w_timeout   = w_acting && !w_motor_ack && !w_coin_ack && (r_cnt == TO_LAST);
    assign w_gap_done  = (r_state == S_GAP) && (r_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {vend_i, w_ncoins};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_state_nxt = w_head[2] ? S_MOTOR : S_COIN;
            end
            S_MOTOR: begin
                if (w_motor_ack)    w_state_nxt = S_GAP;
                else if (w_timeout) w_state_nxt = S_FAULT;
            end
            S_COIN: begin
                if (w_coin_ack)     w_state_nxt = S_GAP;
                else if (w_timeout) w_state_nxt = S_FAULT;
            end
            S_GAP: begin
                if (w_gap_done) begin
                    if (r_vend)               w_state_nxt = S_MOTOR;
                    else if (r_coins != 2'd0) w_state_nxt = S_COIN;
                    else                      w_state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                if (clr) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        motor_on   = (r_state == S_MOTOR);
        coin_eject = (r_state == S_COIN);
        busy       = (r_level != '0) || (r_state != S_IDLE);
    end

    // One counter serves both the ack timeout and the guard gap; any state change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (w_acting || (r_state == S_GAP)) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vend  <= 1'b0;
            r_coins <= 2'd0;
        end else if (w_pop) begin
            r_vend  <= w_head[2];
            r_coins <= w_head[1:0];
        end else if (w_motor_ack) begin
            r_vend  <= 1'b0;
        end else if (w_coin_ack) begin
            r_coins <= r_coins - 2'd1;
        end else if (w_timeout) begin
            r_vend  <= 1'b0;
            r_coins <= 2'd0;
        end
    end

    // A timeout outranks a coincident clr so the fault is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_timeout)                        r_fault <= 1'b1;
            else if (clr && (r_state == S_FAULT)) r_fault <= 1'b0;
            if (w_drop)   r_overflow <= 1'b1;
            else if (clr) r_overflow <= 1'b0;
        end
    end

    assign fault    = r_fault;
    assign overflow = r_overflow;
    assign level    = r_level;

`ifdef VEND_DISP_STATS_EN
    logic [15:0] r_vend_cnt;
    logic [15:0] r_coin_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vend_cnt <= '0;
            r_coin_cnt <= '0;
        end else begin
            if (w_motor_ack && (r_vend_cnt != 16'hFFFF)) r_vend_cnt <= r_vend_cnt + 16'd1;
            if (w_coin_ack && (r_coin_cnt != 16'hFFFF))  r_coin_cnt <= r_coin_cnt + 16'd1;
        end
    end

    assign vend_count = r_vend_cnt;
    assign coin_count = r_coin_cnt;
`else
    assign vend_count = '0;
    assign coin_count = '0;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed self-checking bench for vend_dispense_ctrl (DEPTH=4, TIMEOUT=20, GAP=4).
module tb_vend_dispense_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;
    localparam int GAP     = 4;
`ifdef VEND_DISP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vend_i = 1'b0;
    logic [1:0]  change_i = 2'b00;
    logic        motor_done = 1'b0;
    logic        coin_ack = 1'b0;
    logic        clr = 1'b0;
    logic        motor_on;
    logic        coin_eject;
    logic        busy;
    logic        fault;
    logic        overflow;
    logic [2:0]  level;
    logic [15:0] vend_count;
    logic [15:0] coin_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_vend = 0;
    int exp_coin = 0;

    vend_dispense_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .vend_i(vend_i), .change_i(change_i),
        .motor_on(motor_on), .motor_done(motor_done),
        .coin_eject(coin_eject), .coin_ack(coin_ack), .clr(clr),
        .busy(busy), .fault(fault), .overflow(overflow), .level(level),
        .vend_count(vend_count), .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Acks every request one cycle after it appears; counts request-high cycles.
    task automatic run_until_idle(input int max_cyc, output int motors, output int coins, output int cyc);
        motors = 0; coins = 0; cyc = 0;
        while (busy && cyc < max_cyc) begin
            if (motor_on)   motors++;
            if (coin_eject) coins++;
            motor_done = motor_on;
            coin_ack   = coin_eject;
            step(1);
            cyc++;
        end
        motor_done = 1'b0;
        coin_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_checks++;
        if ({motor_on, coin_eject, busy, fault, overflow} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 00000", {motor_on, coin_eject, busy, fault, overflow});
        end
        n_checks++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d required 0", level); end
        n_checks++;
        if ({vend_count, coin_count} !== 32'd0) begin
            n_fail++; $display("FAIL reset_counts: got %0d/%0d required 0/0", vend_count, coin_count);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_vend_only();
        int hi;
        vend_i = 1'b1; step(1); vend_i = 1'b0;
        n_checks++;
        if (level !== 3'd1 || motor_on !== 1'b0) begin
            n_fail++; $display("FAIL vend_capture: got level %0d motor %b required 1/0", level, motor_on);
        end
        step(1);
        n_checks++;
        if (motor_on !== 1'b1 || level !== 3'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL vend_pop: got motor %b level %0d busy %b required 1/0/1", motor_on, level, busy);
        end
        hi = 1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (motor_on) hi++;
        end
        n_checks++;
        if (hi !== 5) begin n_fail++; $display("FAIL motor_width: got %0d required 5", hi); end
        motor_done = 1'b1; step(1); motor_done = 1'b0;
        n_checks++;
        if (motor_on !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL motor_release: got motor %b busy %b required 0/1", motor_on, busy);
        end
        step(GAP - 1);
        n_checks++;
        if (busy !== 1'b1 || motor_on !== 1'b0) begin
            n_fail++; $display("FAIL gap_hold: got busy %b motor %b required 1/0", busy, motor_on);
        end
        step(1);
        exp_vend++;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_end_idle: got busy %b required 0", busy); end
        n_checks++;
        if (vend_count !== (STATS ? 16'(exp_vend) : 16'd0)) begin
            n_fail++; $display("FAIL vend_count_1: got %0d required %0d", vend_count, STATS ? exp_vend : 0);
        end
    endtask

    task automatic test_vend_change10();
        int t;
        int m_at[$];
        int c_at[$];
        vend_i = 1'b1; change_i = 2'b10; step(1); vend_i = 1'b0; change_i = 2'b00;
        n_checks++;
        if (level !== 3'd1) begin n_fail++; $display("FAIL v10_capture: got level %0d required 1", level); end
        step(1);
        t = 0;
        while (busy && t < 100) begin
            if (motor_on)   m_at.push_back(t);
            if (coin_eject) c_at.push_back(t);
            motor_done = motor_on;
            coin_ack   = coin_eject;
            step(1);
            t++;
        end
        motor_done = 1'b0; coin_ack = 1'b0;
        exp_vend++; exp_coin += 2;
        n_checks++;
        if (t !== 15) begin n_fail++; $display("FAIL v10_duration: got %0d cycles required 15", t); end
        n_checks++;
        if (m_at.size() !== 1 || m_at[0] !== 0) begin
            n_fail++; $display("FAIL v10_motor: got %0d pulses first at %0d required 1 at 0", m_at.size(), m_at[0]);
        end
        n_checks++;
        if (c_at.size() !== 2 || c_at[0] !== 5 || c_at[1] !== 10) begin
            n_fail++; $display("FAIL v10_coins: got %0d pulses at %0d,%0d required 2 at 5,10", c_at.size(), c_at[0], c_at[1]);
        end
        n_checks++;
        if (vend_count !== (STATS ? 16'(exp_vend) : 16'd0) || coin_count !== (STATS ? 16'(exp_coin) : 16'd0)) begin
            n_fail++; $display("FAIL v10_stats: got %0d/%0d", vend_count, coin_count);
        end
    endtask

    task automatic test_overflow_timeout();
        logic [14:0] lv_seq;
        int motors, coins, cyc;
        for (int i = 0; i < 5; i++) begin
            vend_i = 1'b1; step(1);
            lv_seq = {lv_seq[11:0], level};
        end
        vend_i = 1'b0;
        n_checks++;
        if (lv_seq !== {3'd1, 3'd1, 3'd2, 3'd3, 3'd4}) begin
            n_fail++; $display("FAIL ovf_level_seq: got %h required %h", lv_seq, {3'd1, 3'd1, 3'd2, 3'd3, 3'd4});
        end
        n_checks++;
        if (overflow !== 1'b0 || motor_on !== 1'b1) begin
            n_fail++; $display("FAIL ovf_no_drop: got ovf %b motor %b required 0/1", overflow, motor_on);
        end
        vend_i = 1'b1; step(1); vend_i = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            n_fail++; $display("FAIL ovf_drop: got ovf %b level %0d required 1/4", overflow, level);
        end
        clr = 1'b1; step(1); clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || level !== 3'd4 || fault !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clr: got ovf %b level %0d fault %b required 0/4/0", overflow, level, fault);
        end
        // Motor entered 5 edges ago; timeout lands 20 edges after entry.
        step(TIMEOUT - 6);
        n_checks++;
        if (motor_on !== 1'b1 || fault !== 1'b0) begin
            n_fail++; $display("FAIL to_before: got motor %b fault %b required 1/0", motor_on, fault);
        end
        clr = 1'b1; step(1); clr = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || motor_on !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL to_fire: got fault %b motor %b busy %b required 1/0/1", fault, motor_on, busy);
        end
        step(2);
        n_checks++;
        if (fault !== 1'b1 || motor_on !== 1'b0 || level !== 3'd4) begin
            n_fail++; $display("FAIL fault_hold: got fault %b motor %b level %0d required 1/0/4", fault, motor_on, level);
        end
        clr = 1'b1; step(1); clr = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || motor_on !== 1'b0) begin
            n_fail++; $display("FAIL fault_clr: got fault %b motor %b required 0/0", fault, motor_on);
        end
        step(1);
        n_checks++;
        if (motor_on !== 1'b1 || level !== 3'd3) begin
            n_fail++; $display("FAIL resume: got motor %b level %0d required 1/3", motor_on, level);
        end
        run_until_idle(200, motors, coins, cyc);
        exp_vend += 4;
        n_checks++;
        if (cyc >= 200 || motors !== 4 || coins !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drain: got cyc %0d motors %0d coins %0d busy %b required <200/4/0/0", cyc, motors, coins, busy);
        end
        n_checks++;
        if (vend_count !== (STATS ? 16'(exp_vend) : 16'd0)) begin
            n_fail++; $display("FAIL drain_stats: got %0d required %0d", vend_count, STATS ? exp_vend : 0);
        end
    endtask

    task automatic test_async_reset();
        int act;
        change_i = 2'b01; step(1); change_i = 2'b00;
        step(1);
        n_checks++;
        if (coin_eject !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got coin %b required 1", coin_eject); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({motor_on, coin_eject, busy, fault, overflow} !== 5'b0 || level !== 3'd0) begin
            n_fail++; $display("FAIL arst_now: got flags %b level %0d required 00000/0", {motor_on, coin_eject, busy, fault, overflow}, level);
        end
        exp_vend = 0; exp_coin = 0;
        n_checks++;
        if ({vend_count, coin_count} !== 32'd0) begin
            n_fail++; $display("FAIL arst_counts: got %0d/%0d required 0/0", vend_count, coin_count);
        end
        @(negedge clk) rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (motor_on || coin_eject || busy) act++;
        end
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL arst_quiet: got %0d active cycles required 0", act); end
    endtask

    task automatic test_reserved();
        int act, motors, coins, cyc;
        change_i = 2'b11; step(1); change_i = 2'b00;
        n_checks++;
        if (level !== 3'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rsv_ignored: got level %0d busy %b required 0/0", level, busy);
        end
        act = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (motor_on || coin_eject) act++;
        end
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL rsv_quiet: got %0d active cycles required 0", act); end
        vend_i = 1'b1; change_i = 2'b11; step(1); vend_i = 1'b0; change_i = 2'b00;
        n_checks++;
        if (level !== 3'd1) begin n_fail++; $display("FAIL rsv_vend_capture: got level %0d required 1", level); end
        step(1);
        run_until_idle(100, motors, coins, cyc);
        exp_vend++;
        n_checks++;
        if (cyc >= 100 || motors !== 1 || coins !== 0) begin
            n_fail++; $display("FAIL rsv_vend_run: got cyc %0d motors %0d coins %0d required <100/1/0", cyc, motors, coins);
        end
        n_checks++;
        if (coin_count !== 16'd0 || vend_count !== (STATS ? 16'(exp_vend) : 16'd0)) begin
            n_fail++; $display("FAIL rsv_stats: got %0d/%0d", vend_count, coin_count);
        end
    endtask

    initial begin
        test_reset();
        test_vend_only();
        test_vend_change10();
        test_overflow_timeout();
        test_async_reset();
        test_reserved();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
